// File: rtl/lcplc_seq_pkg.sv
// Shared types and default parameter constants for the LCPLC input sequencer.
package lcplc_seq_pkg;

    localparam int unsigned DEF_DATA_WIDTH         = 16;
    localparam int unsigned DEF_MAX_SLICE_SIZE_LOG = 8;
    localparam int unsigned DEF_BAND_WIDTH         = 10;
    localparam int unsigned DEF_BLOCK_WIDTH        = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } seq_state_e;

endpackage

// File: rtl/lcplc_nested_counter.sv
// One level of the nested col/row/band/blk counter: counts handshakes up to
// a latched limit, wraps to zero there and reports a carry to the next level.
module lcplc_nested_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             step,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] value,
    output logic             at_last,
    output logic             carry
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    assign value   = value_q;
    assign at_last = (value_q == limit);
    assign carry   = step && at_last;

    // Next count: clear on new image, wrap at the limit, else increment on step.
    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (step) begin
            if (at_last) begin
                value_d = '0;
            end else begin
                value_d = value_q + WIDTH'(1);
            end
        end else begin
            value_d = value_q;
        end
    end

    // Count register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/lcplc_input_sequencer.sv
// LCPLC input sequencer: passes raw samples straight through to the coder and
// tags each with end-of-row/slice/band-set/image flags from nested counters.
// Optional macro LCPLC_SEQ_CFG_CHECK_EN rejects configs whose slice exceeds
// 2**MAX_SLICE_SIZE_LOG samples and reports it on a sticky cfg_error.
module lcplc_input_sequencer
    import lcplc_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH         = DEF_DATA_WIDTH,
    parameter int unsigned MAX_SLICE_SIZE_LOG = DEF_MAX_SLICE_SIZE_LOG,
    parameter int unsigned BAND_WIDTH         = DEF_BAND_WIDTH,
    parameter int unsigned BLOCK_WIDTH        = DEF_BLOCK_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [MAX_SLICE_SIZE_LOG-1:0] cfg_cols_m1,
    input  logic [MAX_SLICE_SIZE_LOG-1:0] cfg_rows_m1,
    input  logic [BAND_WIDTH-1:0]         cfg_bands_m1,
    input  logic [BLOCK_WIDTH-1:0]        cfg_blocks_m1,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_WIDTH-1:0]         s_data,
    output logic                          x_valid,
    input  logic                          x_ready,
    output logic [DATA_WIDTH-1:0]         x_data,
    output logic                          x_last_r,
    output logic                          x_last_s,
    output logic                          x_last_b,
    output logic                          x_last_i,
    input  logic                          out_valid,
    input  logic                          out_ready,
    input  logic                          out_last,
    output logic                          busy,
    output logic                          done,
    output logic                          cfg_error
);

    localparam int unsigned SW = MAX_SLICE_SIZE_LOG;

    seq_state_e             state_q, state_d;
    logic [SW-1:0]          cols_q, cols_d, rows_q, rows_d;
    logic [BAND_WIDTH-1:0]  bands_q, bands_d;
    logic [BLOCK_WIDTH-1:0] blocks_q, blocks_d;
    logic                   done_q, done_d;

    logic                   run_s, hs_s, accept_s, cnt_clr_s;
    logic                   col_last_s, row_last_s, band_last_s, blk_last_s;
    logic                   col_carry_s, row_carry_s, band_carry_s, blk_carry_s;
    logic [SW-1:0]          col_val_s, row_val_s;
    logic [BAND_WIDTH-1:0]  band_val_s;
    logic [BLOCK_WIDTH-1:0] blk_val_s;

    // Zero-latency pass-through while running; everything gated off otherwise.
    assign run_s     = (state_q == ST_RUN);
    assign x_valid   = run_s && s_valid;
    assign s_ready   = run_s && x_ready;
    assign x_data    = s_data;
    assign hs_s      = x_valid && x_ready;
    assign cfg_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

    // Flags only mean something alongside a valid sample.
    assign x_last_r = x_valid && col_last_s;
    assign x_last_s = x_last_r && row_last_s;
    assign x_last_b = x_last_s && band_last_s;
    assign x_last_i = x_last_b && blk_last_s;

`ifdef LCPLC_SEQ_CFG_CHECK_EN
    localparam int unsigned PW = 2 * SW + 2;
    logic [PW-1:0] slice_size_s;
    logic          slice_too_big_s;
    logic          cfg_error_q, cfg_error_d;

    assign slice_size_s    = PW'((PW'(cfg_cols_m1) + PW'(1)) * (PW'(cfg_rows_m1) + PW'(1)));
    assign slice_too_big_s = (slice_size_s > (PW'(1) << SW));
    assign accept_s        = cfg_valid && cfg_ready && !slice_too_big_s;
    assign cfg_error       = cfg_error_q;

    // Sticky error: set by a rejected config, cleared by the next accepted one.
    always_comb begin
        cfg_error_d = cfg_error_q;
        if (cfg_valid && cfg_ready) begin
            cfg_error_d = slice_too_big_s;
        end else begin
            cfg_error_d = cfg_error_q;
        end
    end

    // Error flag register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_error_q <= 1'b0;
        end else begin
            cfg_error_q <= cfg_error_d;
        end
    end
`else
    assign accept_s  = cfg_valid && cfg_ready;
    assign cfg_error = 1'b0;
`endif

    // Next-state, config latch and done pulse.
    always_comb begin
        state_d   = state_q;
        cols_d    = cols_q;
        rows_d    = rows_q;
        bands_d   = bands_q;
        blocks_d  = blocks_q;
        done_d    = 1'b0;
        cnt_clr_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    cols_d    = cfg_cols_m1;
                    rows_d    = cfg_rows_m1;
                    bands_d   = cfg_bands_m1;
                    blocks_d  = cfg_blocks_m1;
                    cnt_clr_s = 1'b1;
                    state_d   = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Coder-output last events are deliberately ignored here.
                if (hs_s && x_last_i) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (out_valid && out_ready && out_last) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched config and done registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cols_q   <= '0;
            rows_q   <= '0;
            bands_q  <= '0;
            blocks_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cols_q   <= cols_d;
            rows_q   <= rows_d;
            bands_q  <= bands_d;
            blocks_q <= blocks_d;
            done_q   <= done_d;
        end
    end

    lcplc_nested_counter #(.WIDTH(SW)) u_col (
        .clk(clk), .rst(rst), .clr(cnt_clr_s), .step(hs_s), .limit(cols_q),
        .value(col_val_s), .at_last(col_last_s), .carry(col_carry_s)
    );

    lcplc_nested_counter #(.WIDTH(SW)) u_row (
        .clk(clk), .rst(rst), .clr(cnt_clr_s), .step(col_carry_s), .limit(rows_q),
        .value(row_val_s), .at_last(row_last_s), .carry(row_carry_s)
    );

    lcplc_nested_counter #(.WIDTH(BAND_WIDTH)) u_band (
        .clk(clk), .rst(rst), .clr(cnt_clr_s), .step(row_carry_s), .limit(bands_q),
        .value(band_val_s), .at_last(band_last_s), .carry(band_carry_s)
    );

    lcplc_nested_counter #(.WIDTH(BLOCK_WIDTH)) u_blk (
        .clk(clk), .rst(rst), .clr(cnt_clr_s), .step(band_carry_s), .limit(blocks_q),
        .value(blk_val_s), .at_last(blk_last_s), .carry(blk_carry_s)
    );

endmodule

// File: tb/tb_lcplc_input_sequencer.sv
// Scoreboard bench for lcplc_input_sequencer: stimulus pushes expected
// {data, flags} per sample; a negedge monitor compares whenever x_valid is up.
module tb_lcplc_input_sequencer;

    localparam int DW = 16;
    localparam int SL = 8;
    localparam int BW = 10;
    localparam int KW = 16;

    logic          clk;
    logic          rst;
    logic          cfg_valid, cfg_ready;
    logic [SL-1:0] cfg_cols_m1, cfg_rows_m1;
    logic [BW-1:0] cfg_bands_m1;
    logic [KW-1:0] cfg_blocks_m1;
    logic          s_valid, s_ready;
    logic [DW-1:0] s_data;
    logic          x_valid, x_ready;
    logic [DW-1:0] x_data;
    logic          x_last_r, x_last_s, x_last_b, x_last_i;
    logic          out_valid, out_ready, out_last;
    logic          busy, done, cfg_error;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [3:0]    flags;   // {i, b, s, r}
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    logic toggle_ready = 1'b0;

    // Hand-derived flag tables {i,b,s,r}: 2x2 slice, 2 bands, 1 block; 1x1 slice, 3 blocks.
    logic [3:0] tbl_a [8] = '{4'b0000, 4'b0001, 4'b0000, 4'b0011,
                              4'b0000, 4'b0001, 4'b0000, 4'b1111};
    logic [3:0] tbl_b [3] = '{4'b0111, 4'b0111, 4'b1111};

    lcplc_input_sequencer dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_cols_m1(cfg_cols_m1), .cfg_rows_m1(cfg_rows_m1),
        .cfg_bands_m1(cfg_bands_m1), .cfg_blocks_m1(cfg_blocks_m1),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .x_last_r(x_last_r), .x_last_s(x_last_s), .x_last_b(x_last_b), .x_last_i(x_last_i),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .done(done), .cfg_error(cfg_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: compare every presented sample against the queue head; pop on handshake.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (x_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_x_valid", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q[0];
                    check("x_data", 32'(x_data), 32'(mon_e.data));
                    check("x_last_flags", 32'({x_last_i, x_last_b, x_last_s, x_last_r}), 32'(mon_e.flags));
                    check("s_ready_follows_x_ready", 32'(s_ready), 32'(x_ready));
                    if (x_ready === 1'b1) begin
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                check("flags_zero_without_valid",
                      32'({x_last_i, x_last_b, x_last_s, x_last_r}), 32'd0);
            end
        end
    end

    task automatic configure(input int c, input int r, input int b, input int k);
        cfg_cols_m1   = SL'(c);
        cfg_rows_m1   = SL'(r);
        cfg_bands_m1  = BW'(b);
        cfg_blocks_m1 = KW'(k);
        cfg_valid     = 1'b1;
        @(negedge clk);
        check("cfg_ready_in_idle", 32'(cfg_ready), 32'd1);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [3:0] f);
        int   budget;
        logic hs;
        exp_q.push_back('{data: d, flags: f});
        s_valid = 1'b1;
        s_data  = d;
        budget  = 0;
        hs      = 1'b0;
        while (!hs && budget < 50) begin
            @(negedge clk);
            hs = x_valid && x_ready;
            @(posedge clk);
            #1;
            if (toggle_ready) x_ready = !x_ready;
            budget++;
        end
        if (!hs) check("send_timeout", 32'd0, 32'd1);
        s_valid = 1'b0;
    endtask

    task automatic flush_and_finish();
        // Source still offers data, but FLUSH must not accept it.
        s_valid = 1'b1;
        #1;
        check("flush_x_valid", 32'(x_valid), 32'd0);
        check("flush_s_ready", 32'(s_ready), 32'd0);
        check("flush_busy", 32'(busy), 32'd1);
        s_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_valid = 1'b1; out_ready = 1'b1; out_last = 1'b1;
        @(negedge clk);
        check("done_before_last", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        out_valid = 1'b0; out_ready = 1'b0; out_last = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
        check("busy_falls_with_done", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("cfg_ready_after_done", 32'(cfg_ready), 32'd1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_x_valid", 32'(x_valid), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cfg_error", 32'(cfg_error), 32'd0);
        @(posedge clk);
        #1;
        exp_q.delete();
        s_valid = 1'b0;
        x_ready = 1'b1;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        check("no_done_after_abort", 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; cfg_valid = 1'b0;
        cfg_cols_m1 = '0; cfg_rows_m1 = '0; cfg_bands_m1 = '0; cfg_blocks_m1 = '0;
        s_valid = 1'b0; s_data = '0; x_ready = 1'b1;
        out_valid = 1'b0; out_ready = 1'b0; out_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_cfg_error", 32'(cfg_error), 32'd0);
        check("reset_x_valid", 32'(x_valid), 32'd0);
        check("reset_s_ready", 32'(s_ready), 32'd0);
        check("reset_cfg_ready", 32'(cfg_ready), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Full-rate image, with a stray coder last event mid-run.
        configure(1, 1, 1, 0);
        check("busy_in_run", 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            send(DW'(16'h0100 + i), tbl_a[i]);
            if (i == 1) begin
                out_valid = 1'b1; out_ready = 1'b1; out_last = 1'b1;
                @(posedge clk);
                #1;
                out_valid = 1'b0; out_ready = 1'b0; out_last = 1'b0;
                check("run_ignores_out_last_busy", 32'(busy), 32'd1);
                check("run_ignores_out_last_done", 32'(done), 32'd0);
            end
        end
        flush_and_finish();

        // Same image with x_ready toggling 1010...
        configure(1, 1, 1, 0);
        x_ready = 1'b1;
        toggle_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(DW'(16'h0200 + i), tbl_a[i]);
        toggle_ready = 1'b0;
        x_ready = 1'b1;
        flush_and_finish();

        // Abort after sample 3 with sample 4 stalled on the bus, then restart cleanly.
        configure(1, 1, 1, 0);
        for (int i = 0; i < 3; i++) send(DW'(16'h0300 + i), tbl_a[i]);
        x_ready = 1'b0;
        exp_q.push_back('{data: 16'h0303, flags: tbl_a[3]});
        s_data  = 16'h0303;
        s_valid = 1'b1;
        pulse_reset();
        configure(1, 1, 1, 0);
        for (int i = 0; i < 8; i++) send(DW'(16'h0400 + i), tbl_a[i]);
        flush_and_finish();

        // 1x1 slices, one band, three blocks.
        configure(0, 0, 0, 2);
        for (int i = 0; i < 3; i++) send(DW'(16'h0500 + i), tbl_b[i]);
        flush_and_finish();

        // Oversized slice (16 x 17 = 272 samples).
        configure(15, 16, 0, 0);
`ifdef LCPLC_SEQ_CFG_CHECK_EN
        check("oversize_cfg_error", 32'(cfg_error), 32'd1);
        check("oversize_busy", 32'(busy), 32'd0);
        configure(15, 15, 0, 0);
        check("legal_cfg_error_cleared", 32'(cfg_error), 32'd0);
        check("legal_busy", 32'(busy), 32'd1);
`else
        check("unchecked_cfg_error", 32'(cfg_error), 32'd0);
        check("unchecked_busy", 32'(busy), 32'd1);
`endif
        pulse_reset();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
